// File: rtl/operand_stack_if.sv
// operand_stack_if: command/data bundle between an execution unit and operand_stack.
//   master : drives cmd, push_data, wb0, wb1, clr_err; observes stack outputs.
//   slave  : the stack itself; consumes commands, drives stack0, stack1, count,
//            empty, full, ovf_err, udf_err.
interface operand_stack_if;
  logic [2:0] cmd;        // 0 NOP,1 PUSH,2 POP,3 POP2,4 WB,5 WBPOP,6 DUP,7 SWAP
  logic [7:0] push_data;
  logic [7:0] wb0;        // write-back for top entry
  logic [7:0] wb1;        // write-back for second entry
  logic       clr_err;
  logic [7:0] stack0;
  logic [7:0] stack1;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       ovf_err;
  logic       udf_err;

  modport master (
    output cmd, push_data, wb0, wb1, clr_err,
    input  stack0, stack1, count, empty, full, ovf_err, udf_err
  );

  modport slave (
    input  cmd, push_data, wb0, wb1, clr_err,
    output stack0, stack1, count, empty, full, ovf_err, udf_err
  );
endinterface

// File: rtl/operand_stack.sv
// operand_stack: DEPTH x 8-bit LIFO operand stack with ALU write-back support.
//   i_clk : clock, all state updates on rising edge
//   i_rst : asynchronous active-high reset (clears count and error flags)
//   bus   : operand_stack_if.slave -- command inputs and stack/status outputs
// stack0/stack1 expose the top two entries combinationally; illegal commands
// are no-ops that set sticky ovf_err/udf_err.
module operand_stack #(
  parameter int unsigned DEPTH = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  operand_stack_if.slave bus
);
  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam logic [3:0]  DepthC = 4'(DEPTH);

  localparam logic [2:0] CmdNop   = 3'd0;
  localparam logic [2:0] CmdPush  = 3'd1;
  localparam logic [2:0] CmdPop   = 3'd2;
  localparam logic [2:0] CmdPop2  = 3'd3;
  localparam logic [2:0] CmdWb    = 3'd4;
  localparam logic [2:0] CmdWbPop = 3'd5;
  localparam logic [2:0] CmdDup   = 3'd6;
  localparam logic [2:0] CmdSwap  = 3'd7;

  logic [7:0]      r_mem [DEPTH];
  logic [3:0]      r_count;
  logic            r_ovf;
  logic            r_udf;

  logic [IdxW-1:0] w_top_idx;
  logic [IdxW-1:0] w_sec_idx;
  logic [IdxW-1:0] w_wr_idx;
  logic            w_has1;
  logic            w_has2;
  logic            w_full;
  logic            w_ok;
  logic            w_ovf_set;
  logic            w_udf_set;
  logic [3:0]      w_count_d;

  // Indices wrap when count is 0/1/DEPTH; they are only used when the command is legal.
  assign w_top_idx = IdxW'(r_count - 4'd1);
  assign w_sec_idx = IdxW'(r_count - 4'd2);
  assign w_wr_idx  = IdxW'(r_count);
  assign w_has1    = (r_count >= 4'd1);
  assign w_has2    = (r_count >= 4'd2);
  assign w_full    = (r_count == DepthC);

  // Legality check and error classification for the sampled command.
  always_comb begin
    w_ok      = 1'b0;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    unique case (bus.cmd)
      CmdNop:  w_ok = 1'b1;
      CmdPush: begin
        w_ok      = !w_full;
        w_ovf_set = w_full;
      end
      CmdPop: begin
        w_ok      = w_has1;
        w_udf_set = !w_has1;
      end
      CmdPop2, CmdWb, CmdWbPop, CmdSwap: begin
        w_ok      = w_has2;
        w_udf_set = !w_has2;
      end
      CmdDup: begin
        // Empty outranks full so DUP with nothing to copy reports underflow.
        w_ok      = w_has1 && !w_full;
        w_udf_set = !w_has1;
        w_ovf_set = w_has1 && w_full;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_count_d = r_count;
    if (w_ok) begin
      unique case (bus.cmd)
        CmdPush, CmdDup:  w_count_d = r_count + 4'd1;
        CmdPop, CmdWbPop: w_count_d = r_count - 4'd1;
        CmdPop2:          w_count_d = r_count - 4'd2;
        default:          w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= 4'd0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_count_d;
      // Set wins over a same-edge clear.
      r_ovf   <= (r_ovf & ~bus.clr_err) | w_ovf_set;
      r_udf   <= (r_udf & ~bus.clr_err) | w_udf_set;
    end
  end

  // Array has no reset: slots at or above count are never observed, and
  // while reset holds count at 0 any write here is invisible.
  always_ff @(posedge i_clk) begin
    if (w_ok) begin
      unique case (bus.cmd)
        CmdPush: r_mem[w_wr_idx] <= bus.push_data;
        CmdDup:  r_mem[w_wr_idx] <= r_mem[w_top_idx];
        CmdWb: begin
          r_mem[w_top_idx] <= bus.wb0;
          r_mem[w_sec_idx] <= bus.wb1;
        end
        CmdWbPop: r_mem[w_sec_idx] <= bus.wb0;
        CmdSwap: begin
          r_mem[w_top_idx] <= r_mem[w_sec_idx];
          r_mem[w_sec_idx] <= r_mem[w_top_idx];
        end
        default: ;
      endcase
    end
  end

  assign bus.stack0  = w_has1 ? r_mem[w_top_idx] : 8'h00;
  assign bus.stack1  = w_has2 ? r_mem[w_sec_idx] : 8'h00;
  assign bus.count   = r_count;
  assign bus.empty   = (r_count == 4'd0);
  assign bus.full    = w_full;
  assign bus.ovf_err = r_ovf;
  assign bus.udf_err = r_udf;
endmodule
